cpu_core: RTL
=============

# cpu_core

Parametrised multi-cycle accumulator CPU, the successor to the fixed 8-bit `cpu`. It generalises data and address width, replaces the internal mock memory with an external single-port memory interface with a req/ack handshake, and adds stores, direct loads, conditional jumps, flags and halt. It sits between the top level and a memory or bus model; instruction fetch and data access share the one port.

## Interface
- `DATA_W`, 8: register, word and bus width (≥4).
- `ADDR_W`, 8: memory address width, so the address space is 2^ADDR_W words.
- `RESET_PC`, 1: PC value loaded on reset.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, synchronous, active-high.
- `mem_addr`  out  ADDR_W  word address of the current request.
- `mem_req`  out  1  request valid.
- `mem_we`  out  1  write enable; only meaningful while `mem_req`=1.
- `mem_wdata`  out  DATA_W  store data (A).
- `mem_rdata`  in  DATA_W  read data, valid in the cycle `mem_ack`=1.
- `mem_ack`  in  1  request completes on this cycle's rising edge.
- `halted`  out  1  core is in HALT.
- `acc`  out  DATA_W  A register (debug).
- `pc_out`  out  ADDR_W  PC (debug).

## Operation
- **Registers:** A and B (DATA_W), PC (ADDR_W), IR (DATA_W), OPR (DATA_W), flags Z and C.
- **Opcode:** IR[3:0]. Operand words are the full DATA_W. Address operands use OPR[ADDR_W-1:0], zero-extended if ADDR_W > DATA_W.
- **Opcodes:**
  - 0 NOP.
  - 1 LDA #: A←imm.
  - 2 LDB #: B←imm.
  - 3 ADDI #: A←A+imm.
  - 4 ADDB: A←A+B.
  - 5 SUBI #: A←A−imm.
  - 6 SUBB: A←A−B.
  - 7 STA a: mem[a]←A.
  - 8 LDM a: A←mem[a].
  - 9 JMP a.
  - A JZ a: jump if Z.
  - B JC a: jump if C.
  - C HALT.
  - D–F: execute as NOP.
- **FSM states:** FETCH, DECODE, OPERAND, MEM, HALT.
  - FETCH: request at PC. On ack: IR←rdata, PC←PC+1, go to DECODE.
  - DECODE: no request.
    - NOP, ADDB, SUBB, D–F: execute now, then FETCH.
    - HALT opcode: go to HALT.
    - All others: go to OPERAND.
  - OPERAND: request at PC. On ack: OPR←rdata, PC←PC+1.
    - Immediates: execute, then FETCH.
    - JMP: PC←addr, then FETCH.
    - JZ/JC taken: PC←addr. Not taken: PC keeps its incremented value. Then FETCH.
    - STA/LDM: go to MEM.
  - MEM: request at OPR address.
    - STA: `mem_we`=1, `mem_wdata`=A.
    - LDM: read; on ack A←rdata.
    - Then FETCH.
  - HALT: no requests, `halted`=1. Only `rst` exits.
- **Arithmetic:** modulo 2^DATA_W.
  - ADD: C←carry-out.
  - SUB: C←borrow, i.e. 1 iff A < operand unsigned.
  - C is unchanged by every other instruction.
- **Z flag:** Z←(new A==0) on every A write (LDA, ADDI, ADDB, SUBI, SUBB, LDM). Unchanged otherwise.
- **Handshake:**
  - `mem_addr`, `mem_we` and `mem_wdata` are stable while `mem_req`=1 and `mem_ack`=0.
  - `mem_req` stays high until an ack edge.
  - `mem_ack` while `mem_req`=0 is ignored.
  - Unbounded wait states are allowed; the FSM holds state.
- **PC and addresses:** PC increments wrap modulo 2^ADDR_W.
- **Reset:**
  - On an edge with `rst`=1: PC←RESET_PC; A, B, IR, OPR, Z, C ←0; state←FETCH.
  - `rst` overrides `mem_ack` and any pending execute.
  - While `rst`=1, `mem_req`=0 and `mem_we`=0 (gated).
- **Reset values:** `halted`=0, `acc`=0, `pc_out`=RESET_PC, `mem_addr`=RESET_PC, `mem_wdata`=0.

## Timing
- Outputs are decoded from registered state only. There is no combinational path from `mem_ack` or `mem_rdata` to any output.
- **Zero-wait latency** (ack in the same cycle as req), in cycles per instruction:
  - NOP, ADDB, SUBB: 2.
  - Immediates, JMP, JZ, JC: 3.
  - STA, LDM: 4.
  - HALT: 2, then stays halted.
- Each wait cycle on a request adds exactly one cycle.
- Register updates are visible on `acc`/`pc_out` the cycle after the executing edge.
- The first `mem_req` after reset is asserted in the cycle after `rst` falls, with `mem_addr`=RESET_PC.

## Test plan
- **Base program, zero-wait:** memory[1..8] = LDA 4; LDB 100; ADDB; SUBI 20; HALT.
  - Required: A=84, B=100, Z=0, C=0, PC=9.
  - `halted` rises 13 cycles after reset release.
- **Carry/zero/branch:** LDA 200; ADDI 100 → A=44, C=1. SUBI 44 → A=0, Z=1, C=0. JZ 0x20 → next fetch at 0x20. JC 0x40 not taken → fetch continues sequentially.
- **Store/load:** LDA 0x5A; STA 0x80; LDA 0; LDM 0x80.
  - Required: exactly one `mem_we` cycle, with addr 0x80 and wdata 0x5A.
  - Final A=0x5A, Z=0.
- **Wait states:** repeat the base program with `mem_ack` held low 3 cycles on every request.
  - Required: identical final state.
  - Total cycles = 13 + 3×(number of requests).
  - Request outputs stable during every wait.
- **Reset mid-op:** assert `rst` for 1 cycle while in MEM of STA with `mem_ack`=0.
  - Required: `mem_req`/`mem_we`=0 in the reset cycle, no write, A=0, `pc_out`=1.
  - Then a normal fetch at address 1.
- **Parameters:** DATA_W=16, ADDR_W=10. LDA 0xFFFF; ADDI 1 → A=0, C=1, Z=1. JMP 0x3FF with NOP at 0x3FF → the following fetch is at address 0 (wrap).

Source files
------------

// File: rtl/cpu_core.sv
// cpu_core: multi-cycle accumulator CPU with one shared memory port.
// Instruction fetch, operand fetch and data access all go through the same
// req/ack port. The handshake can stall for any number of cycles.
//   clk, rst            : rising-edge clock, synchronous active-high reset
//   mem_addr/req/we     : request address, request valid, write enable
//   mem_wdata           : store data (always the A register)
//   mem_rdata/mem_ack   : read data, and the cycle in which the request completes
//   halted, acc, pc_out : debug view of the HALT state, the A register and the PC
module cpu_core #(
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned ADDR_W   = 8,
   parameter int unsigned RESET_PC = 1
) (
   input  logic              clk,
   input  logic              rst,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_req,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic              halted,
   output logic [DATA_W-1:0] acc,
   output logic [ADDR_W-1:0] pc_out
);

   localparam logic [ADDR_W-1:0] PC_RST = ADDR_W'(RESET_PC);

   localparam logic [3:0] OP_LDA  = 4'h1, OP_LDB = 4'h2, OP_ADDI = 4'h3,
                          OP_ADDB = 4'h4, OP_SUBI = 4'h5, OP_SUBB = 4'h6,
                          OP_STA  = 4'h7, OP_LDM = 4'h8, OP_JMP  = 4'h9,
                          OP_JZ   = 4'hA, OP_JC  = 4'hB, OP_HALT = 4'hC;

   typedef enum logic [2:0] {S_FETCH, S_DECODE, S_OPERAND, S_MEM, S_HALT} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [DATA_W-1:0] a_q, a_d, b_q, b_d, ir_q, ir_d, opr_q, opr_d;
   logic              z_q, z_d, c_q, c_d;

   logic [3:0]        op;
   logic [DATA_W-1:0] alu_opnd;
   logic [DATA_W:0]   add_res, sub_res;
   logic [ADDR_W-1:0] rd_addr, opr_addr;
   logic              unused_bits;

   // Address operands are truncated or zero-extended to ADDR_W.
   assign rd_addr     = ADDR_W'(mem_rdata);
   assign opr_addr    = ADDR_W'(opr_q);
   assign unused_bits = ^{ir_q, opr_q};

   assign op = ir_q[3:0];

   // Register-operand ops execute in DECODE. Immediate ops execute on the
   // OPERAND ack, and take their operand straight from the read bus.
   // The extra top bit holds the carry for an add, or the borrow for a subtract.
   assign alu_opnd = (state_q == S_DECODE) ? b_q : mem_rdata;
   assign add_res  = {1'b0, a_q} + {1'b0, alu_opnd};
   assign sub_res  = {1'b0, a_q} - {1'b0, alu_opnd};

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      a_d     = a_q;
      b_d     = b_q;
      ir_d    = ir_q;
      opr_d   = opr_q;
      z_d     = z_q;
      c_d     = c_q;
      case (state_q)
         S_FETCH: if (mem_ack) begin
            ir_d    = mem_rdata;
            pc_d    = pc_q + 1'b1;
            state_d = S_DECODE;
         end
         S_DECODE: begin
            state_d = S_FETCH;
            case (op)
               OP_ADDB: begin
                  a_d = add_res[DATA_W-1:0];
                  c_d = add_res[DATA_W];
                  z_d = (a_d == '0);
               end
               OP_SUBB: begin
                  a_d = sub_res[DATA_W-1:0];
                  c_d = sub_res[DATA_W];
                  z_d = (a_d == '0);
               end
               OP_HALT: state_d = S_HALT;
               OP_LDA, OP_LDB, OP_ADDI, OP_SUBI, OP_STA, OP_LDM,
               OP_JMP, OP_JZ, OP_JC: state_d = S_OPERAND;
               default: ;
            endcase
         end
         S_OPERAND: if (mem_ack) begin
            opr_d   = mem_rdata;
            pc_d    = pc_q + 1'b1;
            state_d = S_FETCH;
            case (op)
               OP_LDA: begin
                  a_d = mem_rdata;
                  z_d = (a_d == '0);
               end
               OP_LDB: b_d = mem_rdata;
               OP_ADDI: begin
                  a_d = add_res[DATA_W-1:0];
                  c_d = add_res[DATA_W];
                  z_d = (a_d == '0);
               end
               OP_SUBI: begin
                  a_d = sub_res[DATA_W-1:0];
                  c_d = sub_res[DATA_W];
                  z_d = (a_d == '0);
               end
               OP_STA, OP_LDM: state_d = S_MEM;
               OP_JMP: pc_d = rd_addr;
               OP_JZ:  if (z_q) pc_d = rd_addr;
               OP_JC:  if (c_q) pc_d = rd_addr;
               default: ;
            endcase
         end
         S_MEM: if (mem_ack) begin
            state_d = S_FETCH;
            if (op == OP_LDM) begin
               a_d = mem_rdata;
               z_d = (a_d == '0);
            end
         end
         default: ;  // S_HALT: only reset leaves
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_FETCH;
         pc_q    <= PC_RST;
         a_q     <= '0;
         b_q     <= '0;
         ir_q    <= '0;
         opr_q   <= '0;
         z_q     <= 1'b0;
         c_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         a_q     <= a_d;
         b_q     <= b_d;
         ir_q    <= ir_d;
         opr_q   <= opr_d;
         z_q     <= z_d;
         c_q     <= c_d;
      end
   end

   // Port outputs come only from registered state, so they hold steady
   // across wait cycles. The only exception is the rst gate on req/we.
   always_comb begin
      mem_req = 1'b0;
      mem_we  = 1'b0;
      if (!rst) begin
         case (state_q)
            S_FETCH, S_OPERAND: mem_req = 1'b1;
            S_MEM: begin
               mem_req = 1'b1;
               mem_we  = (op == OP_STA);
            end
            default: ;
         endcase
      end
   end

   assign mem_addr  = (state_q == S_MEM) ? opr_addr : pc_q;
   assign mem_wdata = a_q;
   assign halted    = (state_q == S_HALT);
   assign acc       = a_q;
   assign pc_out    = pc_q;

endmodule
